// File: rtl/crg_dout_serializer.sv
// -----------------------------------------------------------------------------
// crg_dout_serializer
//   Output stage behind the CRG core. Complete results {a,b,c,e} are queued in
//   a small FIFO of whole results. Each result is sent on the shared data bus
//   as NUM_BEATS beats of LEN_INOUT bits, most significant word first. The FIFO
//   absorbs host stalls so that CRG output is not lost. Single clock domain.
//
// Ports
//   clk_i         clock, all logic on posedge
//   rst_i         synchronous active-high reset
//   din_vld_i     a result is presented on din_i this cycle
//   din_i         {a_o,b_o,c_o,e_o}, MSBs belong to a_o
//   din_rdy_o     registered, a free FIFO entry exists (count < DEPTH)
//   dout_o        current beat, zero while dout_vld_o=0
//   dout_vld_o    dout_o is valid
//   dout_rdy_i    host takes the beat this cycle
//   dout_first_o  current beat is beat 0 of a result
//   dout_last_o   current beat is the last beat of a result
//   overflow_o    sticky, a push arrived while din_rdy_o=0
//   res_cnt_o     number of results fully sent, wraps at 2^16
// -----------------------------------------------------------------------------
module crg_dout_serializer #(
  parameter int LEN_INOUT = 112,
  parameter int NUM_BEATS = 7,
  parameter int DEPTH     = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           din_vld_i,
  input  logic [LEN_INOUT*NUM_BEATS-1:0] din_i,
  output logic                           din_rdy_o,
  output logic [LEN_INOUT-1:0]           dout_o,
  output logic                           dout_vld_o,
  input  logic                           dout_rdy_i,
  output logic                           dout_first_o,
  output logic                           dout_last_o,
  output logic                           overflow_o,
  output logic [15:0]                    res_cnt_o
);

  localparam int DIN_W  = LEN_INOUT * NUM_BEATS;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ZERO  = PTR_W'(0);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);
  localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(NUM_BEATS - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Pointer increment that wraps modulo DEPTH (DEPTH need not be a power of 2).
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = PTR_ZERO;
    end else begin
      ptr_inc = p + PTR_ONE;
    end
  endfunction

  // Beat k of a result; beat 0 is the most significant word.
  function automatic logic [LEN_INOUT-1:0] sel_beat(input logic [DIN_W-1:0] res,
                                                    input logic [BEAT_W-1:0] k);
    logic [LEN_INOUT-1:0] b;
    b = {LEN_INOUT{1'b0}};
    for (int i = 0; i < NUM_BEATS; i++) begin
      if (k == BEAT_W'(i)) begin
        b = res[LEN_INOUT*(NUM_BEATS-i)-1 -: LEN_INOUT];
      end else begin
        b = b;
      end
    end
    return b;
  endfunction

  logic [DIN_W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 din_rdy_q, din_rdy_d;
  logic                 ovf_q, ovf_d;
  logic [15:0]          res_cnt_q, res_cnt_d;
  state_e               state_q, state_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [LEN_INOUT-1:0] dout_q, dout_d;
  logic                 vld_q, vld_d;
  logic                 first_q, first_d;
  logic                 last_q, last_d;

  logic                 push_s;
  logic                 pop_s;
  logic                 hs_s;
  logic [DIN_W-1:0]     head_s;
  logic [DIN_W-1:0]     nxt_head_s;

  // FIFO bookkeeping, sticky overflow and the serializer FSM next state.
  always_comb begin
    push_s   = din_vld_i & din_rdy_q;
    hs_s     = vld_q & dout_rdy_i;
    pop_s    = hs_s & (beat_q == BEAT_LAST);
    head_s   = mem_q[rd_ptr_q];
    // With only the head stored, the next result can only be the one being
    // pushed in this same cycle, so take it straight from din_i.
    nxt_head_s = (count_q > CNT_ONE) ? mem_q[ptr_inc(rd_ptr_q)] : din_i;

    wr_ptr_d  = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    din_rdy_d = (count_d < DEPTH_C);
    ovf_d     = ovf_q | (din_vld_i & ~din_rdy_q);
    res_cnt_d = pop_s ? (res_cnt_q + 16'd1) : res_cnt_q;

    state_d = state_q;
    beat_d  = beat_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    first_d = first_q;
    last_d  = last_q;

    case (state_q)
      ST_IDLE: begin
        if (count_q != CNT_ZERO) begin
          state_d = ST_SEND;
          beat_d  = BEAT_ZERO;
          dout_d  = sel_beat(head_s, BEAT_ZERO);
          vld_d   = 1'b1;
          first_d = 1'b1;
          last_d  = (BEAT_LAST == BEAT_ZERO);
        end else begin
          vld_d   = 1'b0;
          dout_d  = {LEN_INOUT{1'b0}};
          first_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      ST_SEND: begin
        if (hs_s) begin
          if (beat_q == BEAT_LAST) begin
            if (count_d != CNT_ZERO) begin
              // Next result starts immediately: no bubble between results.
              beat_d  = BEAT_ZERO;
              dout_d  = sel_beat(nxt_head_s, BEAT_ZERO);
              first_d = 1'b1;
              last_d  = (BEAT_LAST == BEAT_ZERO);
            end else begin
              state_d = ST_IDLE;
              beat_d  = BEAT_ZERO;
              dout_d  = {LEN_INOUT{1'b0}};
              vld_d   = 1'b0;
              first_d = 1'b0;
              last_d  = 1'b0;
            end
          end else begin
            beat_d  = beat_q + BEAT_ONE;
            dout_d  = sel_beat(head_s, beat_q + BEAT_ONE);
            first_d = 1'b0;
            last_d  = ((beat_q + BEAT_ONE) == BEAT_LAST);
          end
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = BEAT_ZERO;
        dout_d  = {LEN_INOUT{1'b0}};
        vld_d   = 1'b0;
        first_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q  <= PTR_ZERO;
      rd_ptr_q  <= PTR_ZERO;
      count_q   <= CNT_ZERO;
      din_rdy_q <= 1'b1;
      ovf_q     <= 1'b0;
      res_cnt_q <= 16'd0;
      state_q   <= ST_IDLE;
      beat_q    <= BEAT_ZERO;
      dout_q    <= {LEN_INOUT{1'b0}};
      vld_q     <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      din_rdy_q <= din_rdy_d;
      ovf_q     <= ovf_d;
      res_cnt_q <= res_cnt_d;
      state_q   <= state_d;
      beat_q    <= beat_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  // Result storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= din_i;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign din_rdy_o    = din_rdy_q;
  assign dout_o       = dout_q;
  assign dout_vld_o   = vld_q;
  assign dout_first_o = first_q;
  assign dout_last_o  = last_q;
  assign overflow_o   = ovf_q;
  assign res_cnt_o    = res_cnt_q;

endmodule

// File: tb/tb_crg_dout_serializer.sv
// -----------------------------------------------------------------------------
// tb_crg_dout_serializer
//   Self-checking bench for crg_dout_serializer. A queue-based reference model
//   of accepted results tracks what the bus should show each cycle.
// -----------------------------------------------------------------------------
module tb_crg_dout_serializer;

  localparam int W     = 112;
  localparam int NB    = 7;
  localparam int DEPTH = 2;
  localparam int DW    = W * NB;
  localparam int VW    = 5 + 16 + W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          din_vld = 1'b0;
  logic [DW-1:0] din = '0;
  logic          dout_rdy = 1'b0;
  logic          din_rdy;
  logic [W-1:0]  dout;
  logic          dout_vld;
  logic          dout_first;
  logic          dout_last;
  logic          ovf;
  logic [15:0]   res_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  crg_dout_serializer #(.LEN_INOUT(W), .NUM_BEATS(NB), .DEPTH(DEPTH)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .din_vld_i    (din_vld),
    .din_i        (din),
    .din_rdy_o    (din_rdy),
    .dout_o       (dout),
    .dout_vld_o   (dout_vld),
    .dout_rdy_i   (dout_rdy),
    .dout_first_o (dout_first),
    .dout_last_o  (dout_last),
    .overflow_o   (ovf),
    .res_cnt_o    (res_cnt)
  );

  // ---------------- reference model ----------------
  logic [DW-1:0] mq[$];
  int            mk;
  logic          m_vld, m_rdy, m_ovf;
  logic [15:0]   m_cnt;
  int            m_prev;
  bit            m_pop;

  function automatic logic [W-1:0] beat_of(input logic [DW-1:0] r, input int k);
    logic [DW-1:0] t;
    t = r >> (W * (NB - 1 - k));
    return t[W-1:0];
  endfunction

  function automatic logic [DW-1:0] rand_res();
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 25; i++) r = (r << 32) | DW'($urandom);
    return r;
  endfunction

  function automatic logic [VW-1:0] model_outputs();
    logic [W-1:0] b;
    b = m_vld ? beat_of(mq[0], mk) : '0;
    return {m_vld, m_vld && (mk == 0), m_vld && (mk == NB-1), m_rdy, m_ovf, m_cnt, b};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      mk = 0; m_vld = 1'b0; m_rdy = 1'b1; m_ovf = 1'b0; m_cnt = 16'd0;
    end else begin
      m_prev = mq.size();
      m_pop  = 1'b0;
      if (m_vld && dout_rdy) begin
        if (mk == NB-1) begin
          void'(mq.pop_front());
          mk = 0; m_cnt = m_cnt + 16'd1; m_pop = 1'b1;
        end else begin
          mk = mk + 1;
        end
      end
      if (din_vld) begin
        if (m_rdy) mq.push_back(din);
        else m_ovf = 1'b1;
      end
      if (m_vld) m_vld = m_pop ? (mq.size() > 0) : 1'b1;
      else m_vld = (m_prev > 0);
      m_rdy = (mq.size() < DEPTH);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; din_vld = 1'b0; dout_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL reset_vld got=%b want=0", dout_vld); end
    total++; if (din_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b want=1", din_rdy); end
    total++; if (dout !== '0) begin bad++; $display("FAIL reset_dout got=%h want=0", dout); end
    total++; if ({dout_first, dout_last} !== 2'b00) begin bad++; $display("FAIL reset_fl got=%b%b want=00", dout_first, dout_last); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
    total++; if (res_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", res_cnt); end
  endtask

  task automatic test_single();
    logic [DW-1:0] r;
    logic [W-1:0]  eb;
    r = '0;
    for (int k = 0; k < NB; k++) begin
      eb = {14{8'(k + 1)}};
      r = (r << W) | DW'(eb);
    end
    din = r; din_vld = 1'b1; dout_rdy = 1'b1;
    tick();
    din_vld = 1'b0;
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL single_lat got=%b want=0", dout_vld); end
    for (int i = 0; i < NB; i++) begin
      tick();
      eb = {14{8'(i + 1)}};
      total++;
      if ({dout_vld, dout_first, dout_last, dout} !== {1'b1, i == 0, i == NB-1, eb}) begin
        bad++; $display("FAIL single_beat%0d got=%b%b%b %h want=1%b%b %h",
                        i, dout_vld, dout_first, dout_last, dout, i == 0, i == NB-1, eb);
      end
    end
    tick();
    total++; if ({dout_vld, dout} !== {1'b0, {W{1'b0}}}) begin bad++; $display("FAIL single_end got=%b %h want=0 0", dout_vld, dout); end
    total++; if (res_cnt !== 16'd1) begin bad++; $display("FAIL single_cnt got=%0d want=1", res_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0;
    int          n;
    c0 = res_cnt; n = 0;
    dout_rdy = 1'b1;
    din = rand_res(); din_vld = 1'b1;
    tick();
    din = rand_res();
    tick();
    din_vld = 1'b0;
    for (int c = 0; c < 18; c++) begin
      total++;
      if ({dout_vld, dout_first, dout_last, din_rdy, ovf, res_cnt, dout} !== model_outputs()) begin
        bad++; $display("FAIL b2b_cyc%0d got=%h want=%h", c,
                        {dout_vld, dout_first, dout_last, din_rdy, ovf, res_cnt, dout}, model_outputs());
      end
      if (dout_vld) begin
        if (n != c) begin total++; bad++; $display("FAIL b2b_gap beat=%0d cycle=%0d", n, c); end
        n++;
      end
      tick();
    end
    total++; if (n != 2*NB) begin bad++; $display("FAIL b2b_beats got=%0d want=%0d", n, 2*NB); end
    total++; if (res_cnt !== c0 + 16'd2) begin bad++; $display("FAIL b2b_cnt got=%0d want=%0d", res_cnt, c0 + 16'd2); end
  endtask

  task automatic test_stall();
    logic [DW-1:0] r;
    r = rand_res();
    din = r; din_vld = 1'b1; dout_rdy = 1'b1;
    tick();
    din_vld = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    dout_rdy = 1'b0;
    for (int s = 0; s < 5; s++) begin
      total++;
      if ({dout_vld, dout} !== {1'b1, beat_of(r, 3)}) begin
        bad++; $display("FAIL stall_hold%0d got=%b %h want=1 %h", s, dout_vld, dout, beat_of(r, 3));
      end
      tick();
    end
    dout_rdy = 1'b1;
    total++; if (dout !== beat_of(r, 3)) begin bad++; $display("FAIL stall_b3 got=%h want=%h", dout, beat_of(r, 3)); end
    for (int i = 4; i < NB; i++) begin
      tick();
      total++;
      if ({dout_vld, dout_last, dout} !== {1'b1, i == NB-1, beat_of(r, i)}) begin
        bad++; $display("FAIL stall_beat%0d got=%b%b %h want=1%b %h", i, dout_vld, dout_last, dout, i == NB-1, beat_of(r, i));
      end
    end
    tick();
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL stall_end got=%b want=0", dout_vld); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] r1, r2;
    int            n;
    r1 = rand_res(); r2 = rand_res(); n = 0;
    dout_rdy = 1'b0;
    din = r1; din_vld = 1'b1; tick();
    din = r2; tick();
    total++; if (din_rdy !== 1'b0) begin bad++; $display("FAIL ovf_full got=%b want=0", din_rdy); end
    din = rand_res(); tick();
    din_vld = 1'b0;
    for (int s = 0; s < 3; s++) begin
      total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_sticky%0d got=%b want=1", s, ovf); end
      tick();
    end
    dout_rdy = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (!dout_vld) break;
      total++;
      if (dout !== beat_of((n < NB) ? r1 : r2, n % NB)) begin
        bad++; $display("FAIL ovf_beat%0d got=%h want=%h", n, dout, beat_of((n < NB) ? r1 : r2, n % NB));
      end
      n++;
      tick();
    end
    total++; if (n != 2*NB) begin bad++; $display("FAIL ovf_beats got=%0d want=%0d", n, 2*NB); end
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL ovf_after got=%b want=1", ovf); end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] r;
    din = rand_res(); din_vld = 1'b1; dout_rdy = 1'b1;
    tick();
    din_vld = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    total++; if (dout !== beat_of(din, 4)) begin bad++; $display("FAIL rmid_b4 got=%h want=%h", dout, beat_of(din, 4)); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++;
    if ({dout_vld, din_rdy, res_cnt, ovf} !== {1'b0, 1'b1, 16'd0, 1'b0}) begin
      bad++; $display("FAIL rmid_state got=%b %b %0d %b want=0 1 0 0", dout_vld, din_rdy, res_cnt, ovf);
    end
    r = rand_res();
    din = r; din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    tick();
    total++;
    if ({dout_vld, dout_first, dout} !== {1'b1, 1'b1, beat_of(r, 0)}) begin
      bad++; $display("FAIL rmid_restart got=%b%b %h want=11 %h", dout_vld, dout_first, dout, beat_of(r, 0));
    end
    for (int c = 0; c < 20 && dout_vld; c++) tick();
    total++; if (res_cnt !== 16'd1) begin bad++; $display("FAIL rmid_cnt got=%0d want=1", res_cnt); end
  endtask

  task automatic test_wrap();
    dout_rdy = 1'b1; din_vld = 1'b0;
    force dut.res_cnt_q = 16'hFFFF;
    tick();
    release dut.res_cnt_q;
    m_cnt = 16'hFFFF;
    total++; if (res_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h want=ffff", res_cnt); end
    din = rand_res(); din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
    for (int i = 0; i < NB + 1; i++) tick();
    total++; if ({dout_vld, res_cnt} !== {1'b0, 16'd0}) begin bad++; $display("FAIL wrap_cnt got=%b %h want=0 0000", dout_vld, res_cnt); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      din_vld  = ($urandom_range(0, 2) == 0);
      din      = rand_res();
      dout_rdy = ($urandom_range(0, 3) != 0);
      tick();
      total++;
      if ({dout_vld, dout_first, dout_last, din_rdy, ovf, res_cnt, dout} !== model_outputs()) begin
        bad++; $display("FAIL rand_cyc%0d got=%h want=%h", c,
                        {dout_vld, dout_first, dout_last, din_rdy, ovf, res_cnt, dout}, model_outputs());
      end
    end
    din_vld = 1'b0; dout_rdy = 1'b1;
    for (int c = 0; c < 3*NB; c++) tick();
    total++; if (dout_vld !== 1'b0) begin bad++; $display("FAIL rand_drain got=%b want=0", dout_vld); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
